// File: rtl/video_pkg.sv
// Shared video/SPI definitions for the register block and the sprite unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package video_pkg;

  // SPI command codes; command 0 streams sprite bitmap bytes.
  typedef enum logic [2:0] {
    CMD_SPRITE_DATA = 3'd0,
    CMD_COLOR1      = 3'd1,
    CMD_COLOR2      = 3'd2,
    CMD_COLOR3      = 3'd3,
    CMD_COLOR4      = 3'd4,
    CMD_SPRITE_X    = 3'd5,
    CMD_SPRITE_Y    = 3'd6,
    CMD_MISC        = 3'd7
  } spi_cmd_e;

  localparam int RGB_W        = 6;
  localparam int SPRITE_DIM   = 8;
  localparam int SPRITE_BPP   = 2;
  localparam int SPRITE_BYTES = 16;

  typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/sprite_bitmap.sv
// 8x8 2bpp sprite storage, filled byte-by-byte, with a combinational pixel read port.
// Latency: writes visible on the read port the cycle after the write; reads are combinational.
// Backpressure: none; every data_valid_i strobe is accepted.
module sprite_bitmap
  import video_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_start_i,
  input  logic [2:0] row_i,
  input  logic [2:0] col_i,
  output logic [1:0] idx_o,
  output logic       upload_done_o
);

  logic [7:0] mem [SPRITE_BYTES];
  logic [3:0] ptr;
  logic [3:0] rd_addr;
  logic [7:0] rd_byte;

  // Byte writes, write pointer and upload completion; a start with a
  // simultaneous byte lands that byte at address 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SPRITE_BYTES; i++) mem[i] <= 8'h00;
      ptr           <= 4'd0;
      upload_done_o <= 1'b0;
    end else if (data_start_i) begin
      upload_done_o <= 1'b0;
      if (data_valid_i) begin
        mem[0] <= data_i;
        ptr    <= 4'd1;
      end else begin
        ptr    <= 4'd0;
      end
    end else if (data_valid_i) begin
      mem[ptr] <= data_i;
      ptr      <= ptr + 4'd1;
      if (ptr == 4'd15) upload_done_o <= 1'b1;
    end
  end

  // Row r lives in bytes 2r (cols 0-3) and 2r+1 (cols 4-7); col 0 is the MSB pair.
  assign rd_addr = {row_i, col_i[2]};
  assign rd_byte = mem[rd_addr];

  // Pick the 2-bit pixel out of the addressed byte.
  always_comb begin
    idx_o = 2'd0;
    case (col_i[1:0])
      2'd0: idx_o = rd_byte[7:6];
      2'd1: idx_o = rd_byte[5:4];
      2'd2: idx_o = rd_byte[3:2];
      2'd3: idx_o = rd_byte[1:0];
      default: idx_o = 2'd0;
    endcase
  end

endmodule

// File: rtl/sprite_unit.sv
// Renders one scaled 8x8 sprite over the background colour into an RGB222 pixel stream.
// Latency: rgb_o is registered, 1 clock after hpos_i/vpos_i/display_on_i.
// Backpressure: none; produces a pixel every clock, bitmap writes always accepted.
module sprite_unit
  import video_pkg::*;
#(
  parameter int SCALE_LOG2 = 2,
  parameter int POS_SHIFT  = 1,
  parameter int POS_W      = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  input  logic             data_start_i,
  input  logic [5:0]       color1_i,
  input  logic [5:0]       color2_i,
  input  logic [5:0]       color3_i,
  input  logic [5:0]       color4_i,
  input  logic [7:0]       sprite_x_i,
  input  logic [7:0]       sprite_y_i,
  input  logic [4:0]       misc_i,
  input  logic             frame_start_i,
  input  logic [POS_W-1:0] hpos_i,
  input  logic [POS_W-1:0] vpos_i,
  input  logic             display_on_i,
  output logic [5:0]       rgb_o,
  output logic             upload_done_o
);

  localparam int AW = POS_W + 1;
  localparam logic [AW-1:0] SPR_SIZE = AW'(SPRITE_DIM << SCALE_LOG2);

  logic [7:0]    sh_x, sh_y;
  logic          sh_en;
  logic [7:0]    eff_x, eff_y;
  logic          eff_en;
  logic [AW-1:0] x0, y0, hpos_e, vpos_e, dx, dy;
  logic          hit;
  logic [2:0]    row, col;
  logic [1:0]    idx;
  rgb_t          pix_nxt;
  logic          unused_misc;

  assign unused_misc = ^misc_i[4:1];

  // Latch position/enable once per frame so the sprite cannot tear mid-frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_x  <= 8'd0;
      sh_y  <= 8'd0;
      sh_en <= 1'b0;
    end else if (frame_start_i) begin
      sh_x  <= sprite_x_i;
      sh_y  <= sprite_y_i;
      sh_en <= misc_i[0];
    end
  end

  // The first pixel of a frame already sees the values being latched this edge.
  assign eff_x  = frame_start_i ? sprite_x_i : sh_x;
  assign eff_y  = frame_start_i ? sprite_y_i : sh_y;
  assign eff_en = frame_start_i ? misc_i[0]  : sh_en;

  // One extra bit of headroom keeps origin + size from wrapping.
  assign x0     = AW'(eff_x) << POS_SHIFT;
  assign y0     = AW'(eff_y) << POS_SHIFT;
  assign hpos_e = AW'(hpos_i);
  assign vpos_e = AW'(vpos_i);
  assign dx     = hpos_e - x0;
  assign dy     = vpos_e - y0;
  assign col    = 3'(dx >> SCALE_LOG2);
  assign row    = 3'(dy >> SCALE_LOG2);

  assign hit = eff_en
            && (hpos_e >= x0) && (hpos_e < x0 + SPR_SIZE)
            && (vpos_e >= y0) && (vpos_e < y0 + SPR_SIZE);

  sprite_bitmap u_bitmap (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .data_start_i  (data_start_i),
    .row_i         (row),
    .col_i         (col),
    .idx_o         (idx),
    .upload_done_o (upload_done_o)
  );

  // Choose blank, background or sprite colour; index 0 is transparent.
  always_comb begin
    pix_nxt = color1_i;
    if (!display_on_i) begin
      pix_nxt = '0;
    end else if (hit) begin
      case (idx)
        2'd1:    pix_nxt = color2_i;
        2'd2:    pix_nxt = color3_i;
        2'd3:    pix_nxt = color4_i;
        default: pix_nxt = color1_i;
      endcase
    end
  end

  // Output pixel register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rgb_o <= '0;
    else         rgb_o <= pix_nxt;
  end

endmodule

// File: tb/tb_sprite_unit.sv
module tb_sprite_unit;

  localparam logic [5:0] C1 = 6'h15;
  localparam logic [5:0] C2 = 6'h2A;
  localparam logic [5:0] C3 = 6'h0F;
  localparam logic [5:0] C4 = 6'h30;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] data_i = 8'd0;
  logic       data_valid_i = 1'b0;
  logic       data_start_i = 1'b0;
  logic [5:0] color1_i = C1, color2_i = C2, color3_i = C3, color4_i = C4;
  logic [7:0] sprite_x_i = 8'd0, sprite_y_i = 8'd0;
  logic [4:0] misc_i = 5'd0;
  logic       frame_start_i = 1'b0;
  logic [9:0] hpos_i = 10'd0, vpos_i = 10'd0;
  logic       display_on_i = 1'b0;
  logic [5:0] rgb_o;
  logic       upload_done_o;

  int n_chk = 0;
  int n_fail = 0;

  sprite_unit #(.SCALE_LOG2(2), .POS_SHIFT(1), .POS_W(10)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_start_i(data_start_i), .color1_i(color1_i), .color2_i(color2_i),
    .color3_i(color3_i), .color4_i(color4_i), .sprite_x_i(sprite_x_i),
    .sprite_y_i(sprite_y_i), .misc_i(misc_i), .frame_start_i(frame_start_i),
    .hpos_i(hpos_i), .vpos_i(vpos_i), .display_on_i(display_on_i),
    .rgb_o(rgb_o), .upload_done_o(upload_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       disp;
    logic [5:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a pixel at a negedge; the registered result is sampled one negedge later.
  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic disp,
                     input logic [5:0] exp, input string name);
    @(negedge clk_i);
    hpos_i = h; vpos_i = v; display_on_i = disp;
    @(negedge clk_i);
    chk(name, {2'b00, rgb_o}, {2'b00, exp});
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge clk_i);
    data_i = b; data_valid_i = 1'b1;
    @(negedge clk_i);
    data_valid_i = 1'b0;
  endtask

  task automatic start_upload();
    @(negedge clk_i);
    data_start_i = 1'b1;
    @(negedge clk_i);
    data_start_i = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk_i);
    frame_start_i = 1'b1;
    @(negedge clk_i);
    frame_start_i = 1'b0;
  endtask

  vec_t       tbl [8];
  logic [5:0] row0_exp [8];

  initial begin
    tbl[0] = '{10'd100, 10'd40, 1'b1, C2};
    tbl[1] = '{10'd131, 10'd71, 1'b1, C2};
    tbl[2] = '{10'd115, 10'd55, 1'b1, C2};
    tbl[3] = '{10'd99,  10'd40, 1'b1, C1};
    tbl[4] = '{10'd132, 10'd40, 1'b1, C1};
    tbl[5] = '{10'd100, 10'd39, 1'b1, C1};
    tbl[6] = '{10'd100, 10'd72, 1'b1, C1};
    tbl[7] = '{10'd110, 10'd50, 1'b0, 6'h00};
    row0_exp = '{C1, C2, C3, C4, C4, C3, C2, C1};

    // Reset state
    #12;
    chk("reset_rgb", {2'b00, rgb_o}, 8'h00);
    chk("reset_done", {7'd0, upload_done_o}, 8'h00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pix(10'd200, 10'd100, 1'b1, C1, "bg_after_reset");
    pix(10'd0, 10'd0, 1'b1, C1, "bg_origin");

    // Full upload of idx-1 pixels
    start_upload();
    for (int i = 0; i < 15; i++) wr(8'h55);
    chk("done_before_16th", {7'd0, upload_done_o}, 8'h00);
    wr(8'h55);
    chk("done_after_16th", {7'd0, upload_done_o}, 8'h01);
    sprite_x_i = 8'd50; sprite_y_i = 8'd20; misc_i = 5'd1;
    frame();
    for (int i = 0; i < 8; i++) begin
      pix(tbl[i].h, tbl[i].v, tbl[i].disp, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Mid-frame position change is deferred to the next frame
    sprite_x_i = 8'd60;
    pix(10'd100, 10'd40, 1'b1, C2, "midframe_old_pos");
    pix(10'd120, 10'd40, 1'b1, C2, "midframe_old_pos_in");
    frame();
    pix(10'd100, 10'd40, 1'b1, C1, "newframe_old_gone");
    pix(10'd151, 10'd40, 1'b1, C2, "newframe_new_pos");
    pix(10'd152, 10'd40, 1'b1, C1, "newframe_right_edge");
    // frame_start coincident with a pixel uses the new position at once
    sprite_x_i = 8'd50;
    @(negedge clk_i);
    frame_start_i = 1'b1; hpos_i = 10'd100; vpos_i = 10'd40; display_on_i = 1'b1;
    @(negedge clk_i);
    frame_start_i = 1'b0;
    chk("fs_coincident", {2'b00, rgb_o}, {2'b00, C2});

    // Row-0 index sequence 0,1,2,3,3,2,1,0
    start_upload();
    wr(8'h1B); wr(8'hE4);
    for (int i = 0; i < 14; i++) wr(8'h00);
    for (int k = 0; k < 8; k++) begin
      pix(10'(100 + 4 * k), 10'd40, 1'b1, row0_exp[k], $sformatf("row0_col%0d", k));
    end
    pix(10'd103, 10'd43, 1'b1, C1, "row0_col0_last");
    pix(10'd104, 10'd43, 1'b1, C2, "row0_col1_first");
    pix(10'd104, 10'd44, 1'b1, C1, "row1_transparent");

    // Overflowing upload wraps to byte 0
    start_upload();
    for (int i = 0; i < 16; i++) wr(8'h00);
    wr(8'hC0);
    chk("done_after_17", {7'd0, upload_done_o}, 8'h01);
    wr(8'h03);
    pix(10'd100, 10'd40, 1'b1, C4, "wrap_byte0");
    pix(10'd104, 10'd40, 1'b1, C1, "wrap_byte0_rest");
    pix(10'd128, 10'd40, 1'b1, C4, "wrap_byte1");
    // start + valid together writes byte 0 and leaves the pointer at 1
    @(negedge clk_i);
    data_start_i = 1'b1; data_valid_i = 1'b1; data_i = 8'h40;
    @(negedge clk_i);
    data_start_i = 1'b0; data_valid_i = 1'b0;
    chk("start_valid_done", {7'd0, upload_done_o}, 8'h00);
    pix(10'd100, 10'd40, 1'b1, C2, "start_valid_byte0");
    wr(8'h00);
    pix(10'd128, 10'd40, 1'b1, C1, "start_valid_ptr1");
    pix(10'd100, 10'd40, 1'b1, C2, "start_valid_byte0_kept");

    // Far right / bottom placement
    start_upload();
    for (int i = 0; i < 16; i++) wr(8'h55);
    sprite_x_i = 8'hFF; sprite_y_i = 8'd20;
    frame();
    pix(10'd509, 10'd40, 1'b1, C1, "xff_left_out");
    pix(10'd510, 10'd40, 1'b1, C2, "xff_left_in");
    pix(10'd541, 10'd71, 1'b1, C2, "xff_right_in");
    pix(10'd542, 10'd40, 1'b1, C1, "xff_right_out");
    pix(10'd0, 10'd40, 1'b1, C1, "xff_no_wrap_left");
    sprite_y_i = 8'hF8;
    frame();
    for (int v = 0; v < 32; v += 8) begin
      pix(10'd520, 10'(v), 1'b1, C1, $sformatf("yf8_row%0d", v));
      pix(10'd0, 10'(v), 1'b1, C1, $sformatf("yf8_col0_row%0d", v));
    end
    pix(10'd520, 10'd479, 1'b1, C1, "yf8_last_line");

    // Asynchronous reset mid-line
    sprite_y_i = 8'd20;
    frame();
    pix(10'd520, 10'd40, 1'b1, C2, "pre_reset_hit");
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_rgb", {2'b00, rgb_o}, 8'h00);
    chk("async_reset_done", {7'd0, upload_done_o}, 8'h00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    sprite_x_i = 8'd50; sprite_y_i = 8'd20; misc_i = 5'd1;
    frame();
    pix(10'd100, 10'd40, 1'b1, C1, "post_reset_transparent");
    pix(10'd120, 10'd60, 1'b1, C1, "post_reset_transparent2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
